// File: rtl/key_step_pkg.sv
// -----------------------------------------------------------------------------
// key_step_pkg
//   Shared types and timing defaults for the pushbutton step-pulse conditioner.
//   - key_state_e : per-channel debounce state (2-bit encoding)
//   - CLK_HZ, DEBOUNCE_MS : board clock and debounce window used to derive the
//     default DEBOUNCE_CYCLES of key_step_pulse (10 ms at 50 MHz)
// -----------------------------------------------------------------------------
package key_step_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/key_step_channel.sv
// -----------------------------------------------------------------------------
// key_step_channel
//   One pushbutton channel: synchronizer, debounce FSM and step-pulse generator.
//   Optional auto-repeat is built only when KEY_STEP_AUTO_REPEAT_EN is defined.
//
// Ports
//   clk        in  system clock
//   reset      in  asynchronous, active-high reset
//   key_n      in  raw pushbutton, 0 = pressed, asynchronous to clk
//   step_pulse out one-cycle strobe per accepted press (and per repeat)
//   key_level  out debounced level, 1 = held (HELD or RELEASE_WAIT)
// -----------------------------------------------------------------------------
module key_step_channel
  import key_step_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
`ifdef KEY_STEP_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 10,
  parameter int unsigned REPEAT_PERIOD   = 5
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic step_pulse,
  output logic key_level
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  key_state_e             r_state;
  key_state_e             w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_press_pulse;
  logic                   w_pulse_nxt;
  logic                   r_pulse;
  logic                   r_level;

  // ---- synchronizer: shifts the pressed (inverted) level, reset = released
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ~key_n};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // ---- debounce FSM: next state / counter / entry pulse
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_pulse = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = HELD;
          w_press_pulse = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!w_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A return to pressed is a release bounce: back to HELD, no new pulse.
        if (w_s) begin
          w_state_nxt = HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef KEY_STEP_AUTO_REPEAT_EN
  // REPEAT_PERIOD must not exceed REPEAT_DELAY so both terminal counts fit RPT_W.
  localparam int unsigned      RPT_W       = $clog2(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] r_rpt;
  logic [RPT_W-1:0] w_rpt_nxt;
  logic             r_rpt_armed;
  logic             w_rpt_armed_nxt;
  logic             w_rpt_pulse;

  // ---- auto-repeat: counts only while HELD stays pressed; frozen in
  //      RELEASE_WAIT so a release bounce resumes the same schedule.
  //      r_rpt_armed selects the period once the first repeat has fired.
  always_comb begin
    w_rpt_nxt       = r_rpt;
    w_rpt_armed_nxt = r_rpt_armed;
    w_rpt_pulse     = 1'b0;
    if ((r_state == HELD) && w_s) begin
      if (r_rpt == (r_rpt_armed ? PERIOD_LAST : DELAY_LAST)) begin
        w_rpt_pulse     = 1'b1;
        w_rpt_nxt       = '0;
        w_rpt_armed_nxt = 1'b1;
      end else begin
        w_rpt_nxt = r_rpt + RPT_W'(1);
      end
    end else if ((r_state == IDLE) || (r_state == PRESS_WAIT)) begin
      w_rpt_nxt       = '0;
      w_rpt_armed_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rpt       <= '0;
      r_rpt_armed <= 1'b0;
    end else begin
      r_rpt       <= w_rpt_nxt;
      r_rpt_armed <= w_rpt_armed_nxt;
    end
  end

  assign w_pulse_nxt = w_press_pulse | w_rpt_pulse;
`else
  assign w_pulse_nxt = w_press_pulse;
`endif

  // ---- state and registered outputs; level follows the next state so it
  //      rises in the same cycle as the entry pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_level <= (w_state_nxt == HELD) || (w_state_nxt == RELEASE_WAIT);
    end
  end

  assign step_pulse = r_pulse;
  assign key_level  = r_level;

endmodule

// File: rtl/key_step_pulse.sv
// -----------------------------------------------------------------------------
// key_step_pulse
//   Conditions raw active-low DE1-SoC pushbuttons into clean single-cycle step
//   pulses and debounced press levels. step_pulse[0] feeds the changeStates
//   advance strobe, key_level[1] feeds its reset.
//   Define KEY_STEP_AUTO_REPEAT_EN to build hold-to-repeat pulses; otherwise
//   REPEAT_DELAY / REPEAT_PERIOD have no effect on the logic.
//
// Ports
//   clk        in  system clock (CLOCK_50)
//   reset      in  asynchronous, active-high reset
//   key_n      in  [NUM_KEYS] raw pushbuttons, 0 = pressed
//   step_pulse out [NUM_KEYS] one-cycle strobe per accepted press / repeat
//   key_level  out [NUM_KEYS] debounced state, 1 = held
// -----------------------------------------------------------------------------
module key_step_pulse
  import key_step_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] step_pulse,
  output logic [NUM_KEYS-1:0] key_level
);

  // Elaboration-time guards on the configuration.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("key_step_pulse: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_step_pulse: DEBOUNCE_CYCLES must be at least 2");
  end
  if ((REPEAT_DELAY < 2) || (REPEAT_PERIOD < 1) || (REPEAT_PERIOD > REPEAT_DELAY)) begin : g_bad_repeat
    $error("key_step_pulse: need REPEAT_DELAY >= 2 and 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_step_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_STEP_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .key_n      (key_n[g]),
      .step_pulse (step_pulse[g]),
      .key_level  (key_level[g])
    );
  end

endmodule

// File: tb/tb_key_step_pulse.sv
module tb_key_step_pulse;

  localparam int NK = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NK-1:0] step_pulse;
  logic [NK-1:0] key_level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  key_step_pulse #(
    .NUM_KEYS        (NK),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .step_pulse (step_pulse),
    .key_level  (key_level)
  );

  // Reference model: the debounced level flips once the sampled press value has
  // been steady for DB+1 consecutive samples; samples lag key_n by two edges.
  logic [NK-1:0] m_d1, m_d2, m_prev, m_level, m_pulse;
  int            m_run1 [NK];
  int            m_run0 [NK];
`ifdef KEY_STEP_AUTO_REPEAT_EN
  int            m_hold [NK];
`endif

  function automatic void model_reset();
    m_d1 = '0; m_d2 = '0; m_prev = '0; m_level = '0; m_pulse = '0;
    for (int ch = 0; ch < NK; ch++) begin
      m_run1[ch] = 0;
      m_run0[ch] = 0;
`ifdef KEY_STEP_AUTO_REPEAT_EN
      m_hold[ch] = 0;
`endif
    end
  endfunction

  function automatic void model_edge(input logic [NK-1:0] kn);
    logic samp;
    for (int ch = 0; ch < NK; ch++) begin
      samp       = m_d2[ch];
      m_d2[ch]   = m_d1[ch];
      m_d1[ch]   = ~kn[ch];
      m_pulse[ch] = 1'b0;
      if (samp) begin m_run1[ch]++; m_run0[ch] = 0; end
      else      begin m_run0[ch]++; m_run1[ch] = 0; end
      if (!m_level[ch]) begin
        if (samp && m_run1[ch] == DB + 1) begin
          m_level[ch] = 1'b1;
          m_pulse[ch] = 1'b1;
`ifdef KEY_STEP_AUTO_REPEAT_EN
          m_hold[ch]  = 0;
`endif
        end
      end else if (!samp && m_run0[ch] == DB + 1) begin
        m_level[ch] = 1'b0;
      end
`ifdef KEY_STEP_AUTO_REPEAT_EN
      else if (samp && m_prev[ch]) begin
        m_hold[ch]++;
        if (m_hold[ch] == RD || (m_hold[ch] > RD && (m_hold[ch] - RD) % RP == 0))
          m_pulse[ch] = 1'b1;
      end
`endif
      m_prev[ch] = samp;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(key_n);
    #1;
  endtask

  task automatic settle();
    key_n = '1;
    repeat (14) tick();
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    key_n = '1;
    model_reset();
    repeat (2) tick();
    n_tests++;
    if (step_pulse !== 2'b00) begin n_fail++; $display("FAIL reset_pulse: got %b want 00", step_pulse); end
    n_tests++;
    if (key_level !== 2'b00) begin n_fail++; $display("FAIL reset_level: got %b want 00", key_level); end
    key_n = 2'b00;
    bad = 0;
    repeat (12) begin
      tick();
      if (step_pulse !== 2'b00 || key_level !== 2'b00) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_held_keys: %0d cycles with nonzero outputs, want 0", bad); end
    key_n = '1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (step_pulse !== 2'b00 || key_level !== 2'b00) begin
      n_fail++; $display("FAIL reset_release: got pulse=%b level=%b want 00/00", step_pulse, key_level);
    end
  endtask

  task automatic test_clean_press();
    int pulse_at, level_at, rel_at, npulse;
    pulse_at = -1; level_at = -1; rel_at = -1; npulse = 0;
    key_n[0] = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      n_tests++;
      if (step_pulse !== m_pulse || key_level !== m_level) begin
        n_fail++;
        $display("FAIL press_model cycle %0d: got pulse=%b level=%b want pulse=%b level=%b", i, step_pulse, key_level, m_pulse, m_level);
      end
      if (step_pulse[0] === 1'b1) begin npulse++; if (pulse_at < 0) pulse_at = i; end
      if (key_level[0] === 1'b1 && level_at < 0) level_at = i;
    end
    n_tests++;
    if (pulse_at != 7) begin n_fail++; $display("FAIL press_latency: got %0d want 7", pulse_at); end
    n_tests++;
    if (npulse != 1) begin n_fail++; $display("FAIL press_pulse_count: got %0d want 1", npulse); end
    n_tests++;
    if (level_at != 7) begin n_fail++; $display("FAIL press_level_rise: got %0d want 7", level_at); end
    key_n[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_tests++;
      if (step_pulse !== m_pulse || key_level !== m_level) begin
        n_fail++;
        $display("FAIL release_model cycle %0d: got pulse=%b level=%b want pulse=%b level=%b", i, step_pulse, key_level, m_pulse, m_level);
      end
      if (key_level[0] === 1'b0 && rel_at < 0) rel_at = i;
    end
    n_tests++;
    if (rel_at != 7) begin n_fail++; $display("FAIL release_latency: got %0d want 7", rel_at); end
  endtask

  task automatic test_bounce();
    logic pat [16];
    int   seen;
    for (int i = 0; i < 16; i++) pat[i] = 1'b1;
    pat[0] = 1'b0; pat[1] = 1'b0; pat[3] = 1'b0; pat[4] = 1'b0;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      key_n[0] = pat[i];
      tick();
      n_tests++;
      if (step_pulse !== m_pulse || key_level !== m_level) begin
        n_fail++;
        $display("FAIL bounce_model cycle %0d: got pulse=%b level=%b want pulse=%b level=%b", i, step_pulse, key_level, m_pulse, m_level);
      end
      if (step_pulse[0] === 1'b1 || key_level[0] === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL bounce_no_accept: %0d active cycles, want 0", seen); end
  endtask

  task automatic test_release_bounce();
    int npulse, level_low, rel_at;
    key_n[0] = 1'b0;
    repeat (8) tick();
    n_tests++;
    if (key_level[0] !== 1'b1) begin n_fail++; $display("FAIL rbounce_held: got level %b want 1", key_level[0]); end
    npulse = 0; level_low = 0;
    for (int i = 0; i < 11; i++) begin
      key_n[0] = (i < 2) ? 1'b1 : 1'b0;
      tick();
      n_tests++;
      if (step_pulse !== m_pulse || key_level !== m_level) begin
        n_fail++;
        $display("FAIL rbounce_model cycle %0d: got pulse=%b level=%b want pulse=%b level=%b", i, step_pulse, key_level, m_pulse, m_level);
      end
      if (step_pulse[0] === 1'b1) npulse++;
      if (key_level[0] !== 1'b1) level_low++;
    end
    n_tests++;
    if (npulse != 0) begin n_fail++; $display("FAIL rbounce_no_pulse: got %0d pulses want 0", npulse); end
    n_tests++;
    if (level_low != 0) begin n_fail++; $display("FAIL rbounce_level: level low %0d cycles want 0", level_low); end
    rel_at = -1;
    key_n[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_tests++;
      if (step_pulse !== m_pulse || key_level !== m_level) begin
        n_fail++;
        $display("FAIL rbounce_rel_model cycle %0d: got pulse=%b level=%b want pulse=%b level=%b", i, step_pulse, key_level, m_pulse, m_level);
      end
      if (key_level[0] === 1'b0 && rel_at < 0) rel_at = i;
    end
    n_tests++;
    if (rel_at != 7) begin n_fail++; $display("FAIL rbounce_release_latency: got %0d want 7", rel_at); end
  endtask

  task automatic test_simultaneous();
    int            first_at;
    logic [NK-1:0] first_pat;
    first_at = -1; first_pat = '0;
    key_n = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_tests++;
      if (step_pulse !== m_pulse || key_level !== m_level) begin
        n_fail++;
        $display("FAIL simul_model cycle %0d: got pulse=%b level=%b want pulse=%b level=%b", i, step_pulse, key_level, m_pulse, m_level);
      end
      if (step_pulse !== 2'b00 && first_at < 0) begin first_at = i; first_pat = step_pulse; end
    end
    n_tests++;
    if (first_pat !== 2'b11 || first_at != 7) begin
      n_fail++; $display("FAIL simul_pulse: got %b at cycle %0d want 11 at cycle 7", first_pat, first_at);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    int pulse_at, npulse;
    key_n[1] = 1'b0;
    repeat (8) tick();
    key_n[0] = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (step_pulse !== 2'b00 || key_level !== 2'b00) begin
      n_fail++; $display("FAIL midreset_immediate: got pulse=%b level=%b want 00/00", step_pulse, key_level);
    end
    repeat (2) tick();
    reset = 1'b0;
    pulse_at = -1; npulse = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_tests++;
      if (step_pulse !== m_pulse || key_level !== m_level) begin
        n_fail++;
        $display("FAIL midreset_model cycle %0d: got pulse=%b level=%b want pulse=%b level=%b", i, step_pulse, key_level, m_pulse, m_level);
      end
      if (step_pulse[0] === 1'b1) begin npulse++; if (pulse_at < 0) pulse_at = i; end
    end
    n_tests++;
    if (pulse_at != 7 || npulse != 1) begin
      n_fail++; $display("FAIL midreset_repress: got %0d pulses first at %0d want 1 at 7", npulse, pulse_at);
    end
    settle();
  endtask

  task automatic test_auto_repeat();
    int got [$];
    int exp [$];
`ifdef KEY_STEP_AUTO_REPEAT_EN
    exp = '{0, 10, 15, 20, 25, 30};
`else
    exp = '{0};
`endif
    key_n[0] = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      n_tests++;
      if (step_pulse !== m_pulse || key_level !== m_level) begin
        n_fail++;
        $display("FAIL repeat_model cycle %0d: got pulse=%b level=%b want pulse=%b level=%b", i, step_pulse, key_level, m_pulse, m_level);
      end
      if (step_pulse[0] === 1'b1) got.push_back(i - 7);
    end
    n_tests++;
    if (got.size() != exp.size()) begin
      n_fail++; $display("FAIL repeat_count: got %0d pulses want %0d", got.size(), exp.size());
    end else begin
      for (int k = 0; k < exp.size(); k++) begin
        n_tests++;
        if (got[k] != exp[k]) begin n_fail++; $display("FAIL repeat_offset[%0d]: got +%0d want +%0d", k, got[k], exp[k]); end
      end
    end
    settle();
  endtask

  task automatic test_random();
    int rem [NK];
    for (int ch = 0; ch < NK; ch++) rem[ch] = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      for (int ch = 0; ch < NK; ch++) begin
        if (rem[ch] == 0) begin
          key_n[ch] = 1'($urandom_range(0, 1));
          rem[ch]   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(15, 32)) : int'($urandom_range(1, 8));
        end
        rem[ch]--;
      end
      if (cyc == 450) begin reset = 1'b1; model_reset(); end
      if (cyc == 453) reset = 1'b0;
      tick();
      n_tests++;
      if (step_pulse !== m_pulse || key_level !== m_level) begin
        n_fail++;
        $display("FAIL random_model cycle %0d: got pulse=%b level=%b want pulse=%b level=%b", cyc, step_pulse, key_level, m_pulse, m_level);
      end
    end
    settle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid();
    test_auto_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
